dispensador_troco: RTL and testbench



---
 rtl/dispensador_pkg.sv | 18 +
 rtl/dispensador_troco_temporizador.sv | 27 ++
 rtl/dispensador_troco.sv | 122 ++++++++++++
 tb/tb_dispensador_troco.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dispensador_pkg.sv
// Shared definitions for the change/drink dispenser: state encodings and coin values.
package dispensador_pkg;

    typedef enum logic [2:0] {
        StOcioso      = 3'd0,
        StRefri       = 3'd1,
        StEsperaRefri = 3'd2,
        StEscolhe     = 3'd3,
        StEjeta       = 3'd4,
        StEspera      = 3'd5,
        StFim         = 3'd6,
        StErro        = 3'd7
    } estado_t;

    localparam int unsigned VAL_A = 2;
    localparam int unsigned VAL_B = 1;

endpackage

// File: rtl/dispensador_troco_temporizador.sv
// Sensor-wait timer: counts enabled cycles, flags the last cycle before the timeout limit.
module temporizador_espera #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] cont_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cont_q <= '0;
        end else if (enable_i && !timeout_o) begin
            cont_q <= cont_q + TW'(1);
        end
    end

    // Raised during the TIMEOUT_CYC-th waiting cycle so the FSM leaves exactly on that edge.
    assign timeout_o = enable_i && (cont_q == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dispensador_troco.sv
// Dispense-side controller: ejects a drink and pays change greedily (coin A = 2, coin B = 1).
module dispensador_troco
    import dispensador_pkg::*;
#(
    parameter int unsigned VAL_W       = 3,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned INIT_COINS  = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pedido_valido_i,
    input  logic             pedido_refri_i,
    input  logic [VAL_W-1:0] pedido_troco_i,
    input  logic             sensor_i,
    input  logic             recarga_i,
    output logic             pronto_o,
    output logic             ejeta_refri_o,
    output logic             ejeta_a_o,
    output logic             ejeta_b_o,
    output logic             concluido_o,
    output logic             erro_o,
    output logic [CNT_W-1:0] estoque_a_o,
    output logic [CNT_W-1:0] estoque_b_o,
    output logic [2:0]       saida_estado_o
);

    estado_t          estado_q;
    logic [CNT_W-1:0] estoque_a_q;
    logic [CNT_W-1:0] estoque_b_q;
    logic [VAL_W-1:0] restante_q;
    logic             sel_a_q;
    logic             em_espera;
    logic             timeout;

    assign em_espera = (estado_q == StEsperaRefri) || (estado_q == StEspera);

    temporizador_espera #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_temporizador (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!em_espera),
        .enable_i  (em_espera),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= StOcioso;
            estoque_a_q <= CNT_W'(INIT_COINS);
            estoque_b_q <= CNT_W'(INIT_COINS);
            restante_q  <= '0;
            sel_a_q     <= 1'b0;
        end else begin
            case (estado_q)
                StOcioso: begin
                    // Refill has priority; a simultaneous request is dropped.
                    if (recarga_i) begin
                        estoque_a_q <= CNT_W'(INIT_COINS);
                        estoque_b_q <= CNT_W'(INIT_COINS);
                    end else if (pedido_valido_i) begin
                        restante_q <= pedido_troco_i;
                        estado_q   <= pedido_refri_i ? StRefri : StEscolhe;
                    end
                end
                StRefri: estado_q <= StEsperaRefri;
                StEsperaRefri, StEspera: begin
                    if (sensor_i) begin
                        estado_q <= StEscolhe;
                    end else if (timeout) begin
                        estado_q <= StErro;
                    end
                end
                StEscolhe: begin
                    if (restante_q == '0) begin
                        estado_q <= StFim;
                    end else if (restante_q >= VAL_W'(VAL_A) && estoque_a_q != '0) begin
                        sel_a_q  <= 1'b1;
                        estado_q <= StEjeta;
                    end else if (restante_q >= VAL_W'(VAL_B) && estoque_b_q != '0) begin
                        sel_a_q  <= 1'b0;
                        estado_q <= StEjeta;
                    end else begin
                        estado_q <= StErro;
                    end
                end
                StEjeta: begin
                    if (sel_a_q) begin
                        estoque_a_q <= estoque_a_q - CNT_W'(1);
                        restante_q  <= restante_q - VAL_W'(VAL_A);
                    end else begin
                        estoque_b_q <= estoque_b_q - CNT_W'(1);
                        restante_q  <= restante_q - VAL_W'(VAL_B);
                    end
                    estado_q <= StEspera;
                end
                StFim: estado_q <= StOcioso;
                StErro: begin
                    restante_q <= '0;
                    if (recarga_i) begin
                        estoque_a_q <= CNT_W'(INIT_COINS);
                        estoque_b_q <= CNT_W'(INIT_COINS);
                        estado_q    <= StOcioso;
                    end
                end
                default: estado_q <= StOcioso;
            endcase
        end
    end

    assign pronto_o       = (estado_q == StOcioso) && !recarga_i;
    assign ejeta_refri_o  = (estado_q == StRefri);
    assign ejeta_a_o      = (estado_q == StEjeta) && sel_a_q;
    assign ejeta_b_o      = (estado_q == StEjeta) && !sel_a_q;
    assign concluido_o    = (estado_q == StFim);
    assign erro_o         = (estado_q == StErro);
    assign estoque_a_o    = estoque_a_q;
    assign estoque_b_o    = estoque_b_q;
    assign saida_estado_o = estado_q;

endmodule

// File: tb/tb_dispensador_troco.sv
// Directed bench for dispensador_troco; second instance with INIT_COINS=2 covers stock exhaustion.
module tb_dispensador_troco;

    logic       clk = 1'b0;
    logic       rst;
    logic       pv, pr, sens, rec, use2, auto_s;
    logic [2:0] pt;

    always #5 clk = ~clk;

    logic       pr1, er1, ea1, eb1, co1, xx1;
    logic [3:0] sa1, sb1;
    logic [2:0] st1;
    logic       pr2, er2, ea2, eb2, co2, xx2;
    logic [3:0] sa2, sb2;
    logic [2:0] st2;

    dispensador_troco u_dut (
        .clk            (clk),
        .rst            (rst),
        .pedido_valido_i(pv & ~use2),
        .pedido_refri_i (pr),
        .pedido_troco_i (pt),
        .sensor_i       (sens & ~use2),
        .recarga_i      (rec & ~use2),
        .pronto_o       (pr1),
        .ejeta_refri_o  (er1),
        .ejeta_a_o      (ea1),
        .ejeta_b_o      (eb1),
        .concluido_o    (co1),
        .erro_o         (xx1),
        .estoque_a_o    (sa1),
        .estoque_b_o    (sb1),
        .saida_estado_o (st1)
    );

    dispensador_troco #(
        .INIT_COINS(2)
    ) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .pedido_valido_i(pv & use2),
        .pedido_refri_i (pr),
        .pedido_troco_i (pt),
        .sensor_i       (sens & use2),
        .recarga_i      (rec & use2),
        .pronto_o       (pr2),
        .ejeta_refri_o  (er2),
        .ejeta_a_o      (ea2),
        .ejeta_b_o      (eb2),
        .concluido_o    (co2),
        .erro_o         (xx2),
        .estoque_a_o    (sa2),
        .estoque_b_o    (sb2),
        .saida_estado_o (st2)
    );

    logic       m_pronto, m_er, m_ea, m_eb, m_con, m_err;
    logic [3:0] m_sa, m_sb;
    logic [2:0] m_st;
    assign m_pronto = use2 ? pr2 : pr1;
    assign m_er     = use2 ? er2 : er1;
    assign m_ea     = use2 ? ea2 : ea1;
    assign m_eb     = use2 ? eb2 : eb1;
    assign m_con    = use2 ? co2 : co1;
    assign m_err    = use2 ? xx2 : xx1;
    assign m_sa     = use2 ? sa2 : sa1;
    assign m_sb     = use2 ? sb2 : sb1;
    assign m_st     = use2 ? st2 : st1;

    int n_tests = 0;
    int n_fail  = 0;
    int seq, n_ej, n_con, first_ej, first_err;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pedir(input logic refri, input logic [2:0] troco);
        pv = 1'b1;
        pr = refri;
        pt = troco;
        tick();
        pv = 1'b0;
        pr = 1'b0;
        pt = '0;
    endtask

    // Observes ncyc cycles; eject codes A=1, B=2, drink=3 packed base-4 into seq.
    task automatic run(input int ncyc);
        int cnt;
        cnt = 0;
        seq = 0; n_ej = 0; n_con = 0; first_ej = -1; first_err = -1;
        for (int i = 0; i < ncyc; i++) begin
            sens = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && auto_s) sens = 1'b1;
            end
            if (m_ea || m_eb || m_er) begin
                n_ej++;
                seq = seq * 4 + (m_ea ? 1 : (m_eb ? 2 : 3));
                if (first_ej < 0) first_ej = i;
                cnt = 2;
            end
            if (m_con) n_con++;
            if (m_err && first_err < 0) first_err = i;
            tick();
        end
        sens = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pv = 1'b0; pr = 1'b0; pt = '0; sens = 1'b0; rec = 1'b0;
        use2 = 1'b0; auto_s = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_estado", int'(m_st), 0);
        check("rst_estq_a", int'(m_sa), 8);
        check("rst_estq_b", int'(m_sb), 8);
        check("rst_pronto", int'(m_pronto), 1);
        check("rst_erro", int'(m_err), 0);
        check("rst_pulsos", int'({m_er, m_ea, m_eb, m_con}), 0);
        check("rst2_estq_a", int'(sa2), 2);
        check("rst2_estq_b", int'(sb2), 2);

        // Change of 5: A, A, B.
        pedir(1'b0, 3'd5);
        run(40);
        check("t1_seq", seq, 22);
        check("t1_latencia", first_ej, 1);
        check("t1_conc", n_con, 1);
        check("t1_estq_a", int'(m_sa), 6);
        check("t1_estq_b", int'(m_sb), 7);
        check("t1_pronto", int'(m_pronto), 1);

        // Refill and request together: request dropped, stocks reloaded.
        rec = 1'b1; pv = 1'b1; pt = 3'd3;
        #1;
        check("t6_pronto_rec", int'(m_pronto), 0);
        tick();
        rec = 1'b0; pv = 1'b0; pt = '0;
        run(20);
        check("t6_ejecoes", n_ej, 0);
        check("t6_estq_a", int'(m_sa), 8);
        check("t6_estq_b", int'(m_sb), 8);
        check("t6_estado", int'(m_st), 0);

        // Drink only.
        pedir(1'b1, 3'd0);
        run(20);
        check("t2_seq", seq, 3);
        check("t2_conc", n_con, 1);
        check("t2_estq_a", int'(m_sa), 8);
        check("t2_estq_b", int'(m_sb), 8);

        // No sensor: ESPERA entered at cycle 2, erro expected TIMEOUT_CYC=16 cycles later.
        auto_s = 1'b0;
        pedir(1'b0, 3'd1);
        run(25);
        check("t4_erro_ciclo", first_err, 18);
        check("t4_estado", int'(m_st), 7);
        check("t4_estq_b", int'(m_sb), 7);
        rec = 1'b1;
        tick();
        rec = 1'b0;
        check("t4_rec_estado", int'(m_st), 0);
        check("t4_rec_estq_b", int'(m_sb), 8);
        check("t4_rec_erro", int'(m_err), 0);
        auto_s = 1'b1;

        // Small stock: change of 7 runs both coins out.
        use2 = 1'b1;
        pedir(1'b0, 3'd7);
        run(40);
        check("t3_seq", seq, 90);
        check("t3_conc", n_con, 0);
        check("t3_erro", int'(m_err), 1);
        check("t3_estado", int'(m_st), 7);
        check("t3_estq_a", int'(m_sa), 0);
        check("t3_estq_b", int'(m_sb), 0);
        check("t3_pronto", int'(m_pronto), 0);
        rec = 1'b1;
        tick();
        rec = 1'b0;
        check("t3_rec_estado", int'(m_st), 0);
        check("t3_rec_estq_a", int'(m_sa), 2);
        check("t3_rec_estq_b", int'(m_sb), 2);
        check("t3_rec_erro", int'(m_err), 0);
        use2 = 1'b0;

        // Reset right after the first coin-A pulse.
        pedir(1'b0, 3'd6);
        tick();
        check("t5_ejeta_a", int'(m_ea), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_estado", int'(m_st), 0);
        run(30);
        check("t5_ejecoes", n_ej, 0);
        check("t5_estq_a", int'(m_sa), 8);
        check("t5_estq_b", int'(m_sb), 8);
        check("t5_estado_fim", int'(m_st), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
